// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Hazard and stall controller for a five-stage MIPS pipeline.
//               Compares D-stage source-register demand (Tuse) against the
//               pending results in E and M (Tnew), and tracks the multi-cycle
//               multiply/divide unit with a 4-bit busy counter. Drives the
//               enables and the bubble clear for the stage registers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MULT_CYCLES  busy cycles after a mult/multu start (1..15)
//   DIV_CYCLES   busy cycles after a div/divu start   (1..15)
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous, active-low reset
//   D_rs, D_rt          in   source registers of the D instruction
//   D_tuseRs, D_tuseRt  in   cycles until D needs rs/rt (3 = not used)
//   D_isMdu             in   D instruction is mult/div/mfhi/mflo/mthi/mtlo
//   E_dst, M_dst        in   destination register of E/M (0 = none)
//   E_tnew, M_tnew      in   cycles until the E/M result is available
//   E_mduStart          in   E instruction starts the MDU this cycle
//   E_mduIsDiv          in   qualifies E_mduStart: 1 = div, 0 = mult
//   stall               out  D instruction held this cycle
//   F_en, D_en          out  PC and IF/ID enables
//   E_clr               out  ID/EX synchronous clear (bubble insert)
//   M_en, W_en          out  EX/MEM and MEM/WB enables (always 1)
//   mduBusy             out  MDU busy counter nonzero
//   mduCnt              out  remaining MDU busy cycles
//   stallCnt            out  saturating count of stalled edges
//                            (only with PIPE_STALL_STAT_EN defined)
// Configuration macro:
//   PIPE_STALL_STAT_EN  adds the stallCnt statistics counter and port
// ============================================================================
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuseRs,
  input  logic [1:0]  D_tuseRt,
  input  logic        D_isMdu,
  input  logic [4:0]  E_dst,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        E_mduStart,
  input  logic        E_mduIsDiv,
  output logic        stall,
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        M_en,
  output logic        W_en,
  output logic        mduBusy,
  output logic [3:0]  mduCnt
`ifdef PIPE_STALL_STAT_EN
  ,
  output logic [31:0] stallCnt
`endif
);

  // --------------------------------------------------------------------------
  // Elaboration-time range check: the busy counter is only 4 bits wide.
  // --------------------------------------------------------------------------
  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
    $error("pipe_stall_ctrl: MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("pipe_stall_ctrl: DIV_CYCLES must be in 1..15");
  end

  localparam logic [3:0] C_MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  mdu_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_mdu;

  // --------------------------------------------------------------------------
  // Data hazards. $zero is never a real dependency. A Tuse of 3 can never be
  // below a Tnew (max 2), so unused operands fall out of the compare
  // naturally without a separate qualifier.
  // --------------------------------------------------------------------------
  always_comb begin
    w_stall_rs = 1'b0;
    w_stall_rt = 1'b0;
    if (D_rs != 5'd0) begin
      w_stall_rs = ((D_rs == E_dst) && (D_tuseRs < E_tnew)) ||
                   ((D_rs == M_dst) && (D_tuseRs < M_tnew));
    end
    if (D_rt != 5'd0) begin
      w_stall_rt = ((D_rt == E_dst) && (D_tuseRt < E_tnew)) ||
                   ((D_rt == M_dst) && (D_tuseRt < M_tnew));
    end
  end

  // An MDU instruction in D waits while the unit is busy, and also in the
  // cycle the start is still sitting in E (the counter has not loaded yet).
  assign w_stall_mdu = D_isMdu && (mduBusy || E_mduStart);

  assign stall = w_stall_rs | w_stall_rt | w_stall_mdu;
  assign F_en  = ~stall;
  assign D_en  = ~stall;
  assign E_clr = stall;
  assign M_en  = 1'b1;
  assign W_en  = 1'b1;

  // --------------------------------------------------------------------------
  // MDU busy counter FSM. A start always reloads (restart semantics) and has
  // priority over the decrement.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (E_mduStart) begin
      cnt_d   = E_mduIsDiv ? C_DIV_LOAD : C_MULT_LOAD;
      state_d = BUSY;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
        BUSY: begin
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? IDLE : BUSY;
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign mduCnt  = cnt_q;
  assign mduBusy = (cnt_q != 4'd0);

`ifdef PIPE_STALL_STAT_EN
  // --------------------------------------------------------------------------
  // Saturating stall statistics counter.
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. It compares source-register demand in D against pending results in E and M using Tuse/Tnew, and tracks the multi-cycle multiply/divide unit with a busy counter. It drives the enables and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sits beside the stage registers in the top-level CPU and is their only source of `enable`/clear.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles after a mult/multu start
- `DIV_CYCLES`, 10, busy cycles after a div/divu start

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `D_rs`, `D_rt`  in  5 each  source registers of the instruction in D
- `D_tuseRs`, `D_tuseRt`  in  2 each  cycles until D needs rs/rt; 3 = not used
- `D_isMdu`  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- `E_dst`, `M_dst`  in  5 each  destination register of the E/M instruction (0 = none)
- `E_tnew`, `M_tnew`  in  2 each  cycles until the E/M result is available
- `E_mduStart`  in  1  E instruction starts the MDU this cycle
- `E_mduIsDiv`  in  1  qualifies `E_mduStart`: 1 = div/divu, 0 = mult/multu
- `stall`  out  1  D instruction held this cycle
- `F_en`  out  1  PC enable
- `D_en`  out  1  IF/ID enable
- `E_clr`  out  1  ID/EX synchronous clear (bubble insert)
- `M_en`, `W_en`  out  1 each  EX/MEM and MEM/WB enables; always 1
- `mduBusy`  out  1  MDU busy counter nonzero
- `mduCnt`  out  4  remaining busy cycles

## Operation
- Data stall:
  - `stallRs` = `D_rs`!=0 && ((`D_rs`==`E_dst` && `D_tuseRs`<`E_tnew`) || (`D_rs`==`M_dst` && `D_tuseRs`<`M_tnew`)).
  - `stallRt` is the same expression using rt.
  - Tuse 3 never stalls, because Tnew ≤ 2.
- MDU stall: `stallMdu` = `D_isMdu` && (`mduBusy` || `E_mduStart`).
- `stall` = `stallRs` | `stallRt` | `stallMdu`. This is combinational.
- `F_en` = `D_en` = !`stall`. `E_clr` = `stall`. `M_en` = `W_en` = 1.
- Busy counter, two states: IDLE (`mduCnt`=0) and BUSY (`mduCnt`>0).
  - A clock edge with `E_mduStart`=1 loads `MULT_CYCLES` or `DIV_CYCLES`.
  - Otherwise the counter decrements by 1 while in BUSY.
  - BUSY returns to IDLE when the counter reaches 0.
- `E_mduStart` while BUSY reloads the counter (restart semantics). The load has priority over the decrement.
- Width rule: the counter is 4 bits. The parameters must be in 1..15; otherwise elaboration fails with `$error`.
- `mduBusy` = (`mduCnt`!=0). It is derived from the registered counter only.

## Timing
- Reset (`reset`=0, asynchronous): `mduCnt`=0 and `mduBusy`=0 immediately. Combinational outputs then follow the inputs with the counter at 0.
- Reset asserted mid-count aborts the count. There is no residual stall after release.
- Stall/enable outputs have zero latency from the inputs.
- `mduBusy` rises one cycle after the `E_mduStart` edge and stays high for exactly N cycles (N = 5 or 10).
- A D-stage MDU instruction stalls N+1 cycles when it directly follows the start, which counts the cycle where `E_mduStart` is itself high.
- Simultaneous data and MDU stall produce a single stall; there is no double counting.
- Stall holds F and D and bubbles E. M and W always advance.

## Configuration
- `PIPE_STALL_STAT_EN` defined:
  - Adds output `stallCnt` (32-bit), incremented on every edge with `stall`=1.
  - Saturates at 0xFFFFFFFF.
  - Cleared to 0 by `reset`.
- Undefined: no `stallCnt` port, and no counter logic.

## Test plan
- lw $1 in E (`E_dst`=1, `E_tnew`=2); D addu reads $1 with Tuse 1 -> `stall`=1, `F_en`=`D_en`=0, `E_clr`=1. The next cycle, with `M_tnew`=1, `stall`=0.
- `E_dst`=0, `E_tnew`=2, `D_rs`=0, Tuse 0 -> `stall`=0 (the $zero exemption).
- `E_mduStart`=1, `E_mduIsDiv`=1, then mflo held in D -> `stall`=1 for 11 cycles. `mduCnt` reads 10…1, then 0 and `stall`=0.
- mult start, then a second start 2 cycles later -> `mduCnt` reloads to 5 and busy extends to 5 cycles after the second edge.
- Assert `reset`=0 while `mduCnt`=7 -> `mduCnt`=0 and `mduBusy`=0 before the next clock edge.
- With `PIPE_STALL_STAT_EN`: 3 data-stall cycles plus 11 MDU-stall cycles -> `stallCnt`=14.
